// File: rtl/alu_seq_pipe_if.sv
// alu_seq_pipe_if
// Request/result bus for alu_seq_pipe.
//   master : operand sequencer side (drives in_*, out_ready)
//   slave  : ALU side (drives in_ready, out_*, acc)
// Signals:
//   in_valid/in_ready handshake with in_op, in_a, in_b, in_cin,
//   in_sel_acc, in_wr_acc; out_valid/out_ready handshake with
//   out_result, out_flags {C,Z,N,V}, out_err; acc mirrors the accumulator.
interface alu_seq_pipe_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sel_acc;
    logic             in_wr_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic             out_err;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, in_op, in_a, in_b, in_cin, in_sel_acc, in_wr_acc, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err, acc
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_cin, in_sel_acc, in_wr_acc, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err, acc
    );
endinterface

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe
// Two-stage pipelined ALU with an internal accumulator.
//   S1 registers the accepted request; S2 executes it and registers the
//   result, flags {C,Z,N,V} and error bit. The accumulator is written when
//   S2 loads, so dependent accumulator operations can issue back-to-back.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous flush of pipeline and accumulator
//   bus   : alu_seq_pipe_if.slave (request/result handshakes, acc)
// Configuration:
//   ALU_SEQ_SAT_EN : when defined, ADD/ADDC/SUB/SUBB saturate on signed
//                    overflow (C keeps the raw carry, V still reports 1).
module alu_seq_pipe #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    alu_seq_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDC  = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SUBB  = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOR   = 4'h7;
    localparam logic [3:0] OP_PASSA = 4'h8;
    localparam logic [3:0] OP_NOTA  = 4'h9;
    localparam logic [3:0] OP_SHL1  = 4'hA;
    localparam logic [3:0] OP_SHR1  = 4'hB;
    localparam logic [3:0] OP_ASR1  = 4'hC;
    localparam logic [3:0] OP_CMP   = 4'hD;
    localparam logic [3:0] OP_LDACC = 4'hE;
    localparam logic [3:0] OP_RSVD  = 4'hF;

    logic             s1_valid_r;
    logic [3:0]       s1_op_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_cin_r;
    logic             s1_sel_acc_r;
    logic             s1_wr_acc_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_result_r;
    logic [3:0]       out_flags_r;
    logic             out_err_r;
    logic [WIDTH-1:0] acc_r;

    logic             s2_free_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             accept_s;

    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] bx_s;
    logic             c0_s;
    logic [WIDTH:0]   sum_s;
    logic             add_v_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             z_s;
    logic             n_s;
    logic             v_s;
    logic             err_s;

    assign s2_free_s  = !out_valid_r || bus.out_ready;
    assign s1_adv_s   = s1_valid_r && s2_free_s;
    assign in_ready_s = !clr && (!s1_valid_r || s1_adv_s);
    assign accept_s   = bus.in_valid && in_ready_s;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_r;
    assign bus.out_flags  = out_flags_r;
    assign bus.out_err    = out_err_r;
    assign bus.acc        = acc_r;

    // Shared adder: subtraction is a + ~b + carry-in, so the carry out is the not-borrow flag.
    always_comb begin
        opa_s = s1_sel_acc_r ? acc_r : s1_a_r;
        if ((s1_op_r == OP_SUB) || (s1_op_r == OP_SUBB) || (s1_op_r == OP_CMP)) begin
            bx_s = ~s1_b_r;
        end else begin
            bx_s = s1_b_r;
        end
        case (s1_op_r)
            OP_ADDC: c0_s = s1_cin_r;
            OP_SUB:  c0_s = 1'b1;
            OP_SUBB: c0_s = s1_cin_r;
            OP_CMP:  c0_s = 1'b1;
            default: c0_s = 1'b0;
        endcase
        sum_s   = {1'b0, opa_s} + {1'b0, bx_s} + {{WIDTH{1'b0}}, c0_s};
        add_v_s = (opa_s[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
    end

    // Result and flag selection for the operation held in S1.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        err_s = 1'b0;
        case (s1_op_r)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_v_s;
`ifdef ALU_SEQ_SAT_EN
                // Overflow needs equal operand signs, so A's sign gives the direction.
                if (add_v_s) begin
                    res_s = opa_s[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    res_s = sum_s[WIDTH-1:0];
                end
`endif
            end
            OP_AND:   res_s = opa_s & s1_b_r;
            OP_OR:    res_s = opa_s | s1_b_r;
            OP_XOR:   res_s = opa_s ^ s1_b_r;
            OP_NOR:   res_s = ~(opa_s | s1_b_r);
            OP_PASSA: res_s = opa_s;
            OP_NOTA:  res_s = ~opa_s;
            OP_SHL1: begin
                res_s = {opa_s[WIDTH-2:0], 1'b0};
                c_s   = opa_s[WIDTH-1];
            end
            OP_SHR1: begin
                res_s = {1'b0, opa_s[WIDTH-1:1]};
                c_s   = opa_s[0];
            end
            OP_ASR1: begin
                res_s = {opa_s[WIDTH-1], opa_s[WIDTH-1:1]};
                c_s   = opa_s[0];
            end
            OP_CMP: begin
                res_s = opa_s;
                c_s   = sum_s[WIDTH];
                v_s   = add_v_s;
            end
            OP_LDACC: res_s = opa_s;
            OP_RSVD:  err_s = 1'b1;
            default:  err_s = 1'b1;
        endcase
        // CMP reports the flags of the subtraction, not of the passed-through operand.
        if (s1_op_r == OP_CMP) begin
            z_s = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            n_s = sum_s[WIDTH-1];
        end else if (s1_op_r == OP_RSVD) begin
            z_s = 1'b0;
            n_s = 1'b0;
        end else begin
            z_s = (res_s == {WIDTH{1'b0}});
            n_s = res_s[WIDTH-1];
        end
    end

    // S1: capture accepted requests; empties when its content moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_op_r      <= 4'h0;
            s1_a_r       <= {WIDTH{1'b0}};
            s1_b_r       <= {WIDTH{1'b0}};
            s1_cin_r     <= 1'b0;
            s1_sel_acc_r <= 1'b0;
            s1_wr_acc_r  <= 1'b0;
        end else if (clr) begin
            s1_valid_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r   <= 1'b1;
            s1_op_r      <= bus.in_op;
            s1_a_r       <= bus.in_a;
            s1_b_r       <= bus.in_b;
            s1_cin_r     <= bus.in_cin;
            s1_sel_acc_r <= bus.in_sel_acc;
            s1_wr_acc_r  <= bus.in_wr_acc;
        end else if (s1_adv_s) begin
            s1_valid_r   <= 1'b0;
        end
    end

    // S2: register result/flags; holds them stable until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_flags_r  <= 4'h0;
            out_err_r    <= 1'b0;
        end else if (clr) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_flags_r  <= 4'h0;
            out_err_r    <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= res_s;
            out_flags_r  <= {c_s, z_s, n_s, v_s};
            out_err_r    <= err_s;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    // Accumulator: updated together with the S2 load so the next S1 entry sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {WIDTH{1'b0}};
        end else if (s1_adv_s && (s1_wr_acc_r || (s1_op_r == OP_LDACC))) begin
            acc_r <= res_s;
        end
    end
endmodule
